// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Each execution unit (port 0 = ALU, 1 = LSB,
// 2 = branch) has a small FIFO for completed results. Each cycle at most one
// buffered result is granted in round-robin order. It is broadcast on a
// registered CDB that the ROB, RS and LSB snoop.
//
// Handshake: a result moves on port i at a rising edge when in_valid[i] and
// in_ready[i] are both high. in_ready depends only on internal state and the
// control inputs (rst, rdy, jump_wrong), never on in_valid. A requester holds
// its rob_idx/val stable until the result is accepted. The CDB has no
// back-pressure. cdb_valid is high for one cycle per grant. While rdy is low,
// the CDB outputs are held, and the consumers are frozen in the same way.
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DEPTH  = 2,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      jump_wrong,
    input  logic [N_REQ-1:0]          in_valid,
    output logic [N_REQ-1:0]          in_ready,
    input  logic [N_REQ*ROB_W-1:0]    in_rob_idx,
    input  logic [N_REQ*DATA_W-1:0]   in_val,
    output logic                      cdb_valid,
    output logic [ROB_W-1:0]          cdb_rob_idx,
    output logic [DATA_W-1:0]         cdb_val
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Per-port FIFO storage and bookkeeping
    logic [ROB_W-1:0]  mem_idx [N_REQ][DEPTH];
    logic [DATA_W-1:0] mem_val [N_REQ][DEPTH];
    logic [PTR_W-1:0]  rd_ptr  [N_REQ];
    logic [PTR_W-1:0]  wr_ptr  [N_REQ];
    logic [CNT_W-1:0]  cnt     [N_REQ];

    // Round-robin pointer: this port has the highest priority this cycle
    logic [RR_W-1:0]   rr;

    logic [N_REQ-1:0]  not_empty;
    logic [N_REQ-1:0]  push;
    logic [N_REQ-1:0]  pop;
    logic              grant_any;
    logic [RR_W-1:0]   grant_port;
    logic [RR_W-1:0]   rr_next;
    logic [ROB_W-1:0]  head_idx;
    logic [DATA_W-1:0] head_val;
    logic              advance;

    // Add an offset to a port number, wrapping modulo N_REQ
    function automatic logic [RR_W-1:0] port_add(input logic [RR_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return RR_W'(s);
    endfunction

    // State moves only on a normal cycle. A flush overrides this.
    assign advance = rdy & ~jump_wrong;

    // Derive the accept signal, the push qualifier and the occupancy flag for each port
    always_comb begin
        in_ready  = '0;
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // A full FIFO refuses a push even when it is popped in the same cycle
            in_ready[i]  = rst & rdy & ~jump_wrong & (cnt[i] < CNT_W'(DEPTH));
            push[i]      = in_valid[i] & in_ready[i];
            not_empty[i] = (cnt[i] != '0);
        end
    end

    // Round-robin search for the first non-empty port, starting at rr
    always_comb begin
        logic [RR_W-1:0] cand;
        grant_any  = 1'b0;
        grant_port = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = port_add(rr, k);
            if (!grant_any && not_empty[cand]) begin
                grant_any  = 1'b1;
                grant_port = cand;
            end
        end
        rr_next = port_add(grant_port, 1);
    end

    // Select the pop strobe and the head entry of the granted port
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pop[i] = advance & grant_any & (grant_port == RR_W'(i));
        end
        head_idx = mem_idx[grant_port][rd_ptr[grant_port]];
        head_val = mem_val[grant_port][rd_ptr[grant_port]];
    end

    // FIFO payload storage. The storage is not reset, because counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (push[i]) begin
                mem_idx[i][wr_ptr[i]] <= in_rob_idx[i*ROB_W +: ROB_W];
                mem_val[i][wr_ptr[i]] <= in_val[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers and counts. Reset and flush clear them. A stall freezes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else if (jump_wrong) begin
            for (int i = 0; i < N_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Round-robin pointer. It moves past the granted port and stays put when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
        end else if (jump_wrong) begin
            rr <= '0;
        end else if (rdy && grant_any) begin
            rr <= rr_next;
        end
    end

    // Registered CDB. The payload keeps its last value when there is no grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid   <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_val     <= '0;
        end else if (jump_wrong) begin
            cdb_valid   <= 1'b0;
        end else if (rdy) begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_rob_idx <= head_idx;
                cdb_val     <= head_val;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It collects completed results from the execution units (ALU reservation station, LSB, branch unit) and buffers each unit's results in a small per-port FIFO. Each cycle it grants at most one buffered result, round-robin, and broadcasts it on a single registered CDB, which the reorder buffer, RS and LSB all snoop. A misprediction flush (`jump_wrong`) discards every buffered and in-flight result.

## Interface
- `N_REQ`, default 3: number of requester ports (port 0 = ALU, 1 = LSB, 2 = branch).
- `DEPTH`, default 2: entries per port FIFO (power of two, ≥2).
- `ROB_W`, default 4: ROB index width (16-entry ROB).
- `DATA_W`, default 32: result value width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low (low = reset).
- `rdy`  in  1  global ready; low freezes all state.
- `jump_wrong`  in  1  misprediction flush from the ROB.
- `in_valid`  in  N_REQ  per-port result valid.
- `in_ready`  out  N_REQ  per-port accept.
- `in_rob_idx`  in  N_REQ*ROB_W  destination ROB entry; port i at bits [i*ROB_W +: ROB_W].
- `in_val`  in  N_REQ*DATA_W  result value; port i at bits [i*DATA_W +: DATA_W].
- `cdb_valid`  out  1  broadcast valid, exactly one cycle per grant.
- `cdb_rob_idx`  out  ROB_W  broadcast ROB index.
- `cdb_val`  out  DATA_W  broadcast value.

## Operation
- **Per-port FIFO.** Each port has a FIFO of `DEPTH` entries holding {rob_idx, val}, with read pointer, write pointer and count of width log2(DEPTH)+1. Pointers wrap modulo `DEPTH`.
- **`in_ready[i]`** = `rst` & `rdy` & !`jump_wrong` & (count[i] < `DEPTH`). It depends only on state and control inputs, never on `in_valid`. A full FIFO does not accept a push, even in a cycle where it is popped.
- **Push.** A push occurs on port i when `in_valid[i]` & `in_ready[i]`. `in_valid` while `in_ready` is low is ignored. Requesters hold their data until accepted.
- **Arbitration.** A round-robin pointer `rr` spans 0..N_REQ-1. The candidate order is `rr`, `rr`+1, …, wrapping mod N_REQ. The first port with count > 0 is granted, and `rr` moves to granted+1 mod N_REQ. If no port is non-empty, `rr` is unchanged.
- **Grant.** On a grant, the port's head entry is popped and registered into `cdb_rob_idx`/`cdb_val`, and `cdb_valid` is set to 1. With no grant, `cdb_valid` is set to 0 and `cdb_rob_idx`/`cdb_val` hold their last values.
- **Push and pop together.** The same port may push and pop in one cycle: count is unchanged and both pointers advance.
- **Flush.** `jump_wrong` high at a clock edge clears all counts and pointers, sets `rr` = 0 and `cdb_valid` = 0, and drops that cycle's pushes and grants. Flush takes effect regardless of `rdy`.
- **Stall.** `rdy` low (and no flush): no state changes. `cdb_*` hold their current values, and consumers are frozen likewise.
- **Reset.** While `rst` is low: `cdb_valid` = 0, `cdb_rob_idx` = 0, `cdb_val` = 0, all counts and pointers = 0, `rr` = 0, and `in_ready` = 0.

## Timing
- **Latency.** A result accepted at the edge ending cycle t can be granted in cycle t+1 and is visible on the CDB in cycle t+2. Minimum latency is 2 cycles; there is no bypass from input to CDB.
- **Throughput.** One broadcast per cycle in aggregate. Each port is granted at least once every N_REQ cycles while it is non-empty, so there is no starvation.
- **Visibility.** `cdb_valid` is high for exactly one cycle per grant, unless `rdy` is low, in which case it holds.
- **Reset release.** Reset deassertion is asynchronous. The first push can occur at the first rising edge with `rst` high and `rdy` high.

## Test plan
1. **Single result.** Reset, then port 1 pushes idx 5, val 0xDEADBEEF in cycle 1. Required: `cdb_valid` = 1 with idx 5 and val 0xDEADBEEF in cycle 3 only, and 0 in cycle 4.
2. **Fairness.** All three ports push 2 entries each in consecutive cycles. Required: broadcast port order is 0, 1, 2, 0, 1, 2, then `cdb_valid` = 0.
3. **Full FIFO.** Port 0 pushes 2 entries while ports 1 and 2 are kept non-empty. Required: `in_ready[0]` = 0 while count = 2, a third `in_valid` is not accepted until after a pop, and no result is lost or duplicated.
4. **Flush.** Buffer 4 results, then pulse `jump_wrong` for one cycle while port 2 drives `in_valid`. Required: `in_ready` = 0 during the flush cycle, `cdb_valid` = 0 the next cycle, none of the buffered results or port 2's input is ever broadcast, and a subsequent push broadcasts 2 cycles later.
5. **Stall.** Hold `rdy` = 0 for 3 cycles with `cdb_valid` = 1 (idx 7). Required: `cdb_*` hold idx 7, `in_ready` = 0, and after `rdy` returns the broadcast sequence resumes with nothing lost.
6. **Async reset.** Assert `rst` low mid-cycle with buffered data. Required: `cdb_valid` = 0 immediately (before the next edge), and after release no stale entries are ever broadcast.
